// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU
// replacement and byte-enable CPU writes, using a block-wide memory handshake.
module cache_nway_wb #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int BLOCK_BITS = 2,
    parameter int SET_BITS   = 3,
    parameter int WAY_BITS   = 2,
    localparam int TAG_W     = ADDR_W - SET_BITS - BLOCK_BITS - 2,
    localparam int BLK_W     = WORD_W << BLOCK_BITS,
    localparam int MA_W      = ADDR_W - BLOCK_BITS - 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic                c_read_i,
    input  logic                c_wr_i,
    input  logic [WORD_W/8-1:0] c_byte_en_i,
    input  logic [WORD_W-1:0]   c_wr_data_i,
    output logic                c_busywait_o,
    output logic [WORD_W-1:0]   c_data_o,
    output logic                c_m_read_o,
    output logic                c_m_wr_o,
    output logic [MA_W-1:0]     c_m_address_o,
    output logic [BLK_W-1:0]    c_m_write_data_o,
    input  logic [BLK_W-1:0]    c_m_read_data_i,
    input  logic                m_read_done,
    input  logic                m_write_done
);

    localparam int WAYS  = 1 << WAY_BITS;
    localparam int SETS  = 1 << SET_BITS;
    localparam int WORDS = 1 << BLOCK_BITS;
    localparam int BYTES = WORD_W / 8;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t state, state_next;

    logic [BLK_W-1:0]    data_mem  [SETS][WAYS];
    logic [TAG_W-1:0]    tag_mem   [SETS][WAYS];
    logic [WAY_BITS-1:0] age_mem   [SETS][WAYS];
    logic [WAYS-1:0]     valid_mem [SETS];
    logic [WAYS-1:0]     dirty_mem [SETS];

    logic [BLOCK_BITS-1:0] word_sel;
    logic [SET_BITS-1:0]   set_idx;
    logic [TAG_W-1:0]      tag;
    logic                  request;
    logic                  unused_addr_bits;

    assign word_sel         = address_i[BLOCK_BITS+1:2];
    assign set_idx          = address_i[SET_BITS+BLOCK_BITS+1:BLOCK_BITS+2];
    assign tag              = address_i[ADDR_W-1:SET_BITS+BLOCK_BITS+2];
    assign request          = c_read_i | c_wr_i;
    assign unused_addr_bits = ^address_i[1:0];

    logic                hit;
    logic [WAY_BITS-1:0] hit_way;
    logic [WAY_BITS-1:0] victim;

    // Invalid ways override the oldest way, lowest index first.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        victim  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_mem[set_idx][w] && tag_mem[set_idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (age_mem[set_idx][w] == {WAY_BITS{1'b1}})
                victim = WAY_BITS'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_mem[set_idx][w])
                victim = WAY_BITS'(w);
        end
    end

    logic [BLK_W-1:0]  hit_block;
    logic [BLK_W-1:0]  merged;
    logic [WORD_W-1:0] rd_word;

    always_comb begin
        hit_block = data_mem[set_idx][hit_way];
        merged    = hit_block;
        rd_word   = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (word_sel == BLOCK_BITS'(w)) begin
                rd_word = hit_block[w*WORD_W +: WORD_W];
                for (int b = 0; b < BYTES; b++) begin
                    if (c_byte_en_i[b])
                        merged[w*WORD_W + b*8 +: 8] = c_wr_data_i[b*8 +: 8];
                end
            end
        end
    end

    logic hit_access, miss_start, refill;

    assign hit_access = (state == IDLE) && request && hit;
    assign miss_start = (state == IDLE) && request && !hit;
    assign refill     = (state == ALLOCATE) && m_read_done;
    assign c_data_o   = ((state == IDLE) && hit && c_read_i) ? rd_word : '0;

    logic [WAY_BITS-1:0] victim_q;
    logic [SET_BITS-1:0] set_q;
    logic [TAG_W-1:0]    tag_q;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next       = state;
        c_busywait_o     = 1'b0;
        c_m_read_o       = 1'b0;
        c_m_wr_o         = 1'b0;
        c_m_address_o    = '0;
        c_m_write_data_o = '0;
        case (state)
            IDLE: begin
                if (miss_start) begin
                    c_busywait_o = 1'b1;
                    if (valid_mem[set_idx][victim] && dirty_mem[set_idx][victim])
                        state_next = WRITEBACK;
                    else
                        state_next = ALLOCATE;
                end
            end
            WRITEBACK: begin
                c_busywait_o     = 1'b1;
                c_m_wr_o         = 1'b1;
                c_m_address_o    = {tag_mem[set_q][victim_q], set_q};
                c_m_write_data_o = data_mem[set_q][victim_q];
                if (m_write_done)
                    state_next = ALLOCATE;
            end
            ALLOCATE: begin
                c_busywait_o  = 1'b1;
                c_m_read_o    = 1'b1;
                c_m_address_o = {tag_q, set_q};
                if (m_read_done)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            victim_q <= '0;
            set_q    <= '0;
            tag_q    <= '0;
        end else if (miss_start) begin
            victim_q <= victim;
            set_q    <= set_idx;
            tag_q    <= tag;
        end
    end

    // Refill leaves the LRU ages alone; the retried hit that follows makes the way youngest.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
                for (int w = 0; w < WAYS; w++)
                    age_mem[s][w] <= WAY_BITS'(w);
            end
        end else if (hit_access) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_BITS'(w) == hit_way)
                    age_mem[set_idx][w] <= '0;
                else if (age_mem[set_idx][w] < age_mem[set_idx][hit_way])
                    age_mem[set_idx][w] <= age_mem[set_idx][w] + 1'b1;
            end
            if (c_wr_i)
                dirty_mem[set_idx][hit_way] <= 1'b1;
        end else if (refill) begin
            valid_mem[set_q][victim_q] <= 1'b1;
            dirty_mem[set_q][victim_q] <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (hit_access && c_wr_i) begin
                data_mem[set_idx][hit_way] <= merged;
            end else if (refill) begin
                data_mem[set_q][victim_q] <= c_m_read_data_i;
                tag_mem[set_q][victim_q]  <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_cache_nway_wb.sv
// Self-checking bench for cache_nway_wb: directed vector table, hand-written
// corner sequences and random traffic against a recency-list cache model.
module tb_cache_nway_wb;

    localparam int MEM_WORDS = 512;
    localparam int BUDGET    = 50;
    localparam int NV        = 21;

    logic         clock = 1'b0;
    logic         reset;
    logic [31:0]  address;
    logic         c_read, c_wr;
    logic [3:0]   byte_en;
    logic [31:0]  wr_data;
    logic         busywait;
    logic [31:0]  c_data;
    logic         m_read, m_wr;
    logic [29:0]  m_address;
    logic [127:0] m_write_data;
    logic [127:0] m_read_data;
    logic         m_read_done, m_write_done;

    cache_nway_wb dut (
        .clk_i            (clock),
        .reset_i          (reset),
        .address_i        (address),
        .c_read_i         (c_read),
        .c_wr_i           (c_wr),
        .c_byte_en_i      (byte_en),
        .c_wr_data_i      (wr_data),
        .c_busywait_o     (busywait),
        .c_data_o         (c_data),
        .c_m_read_o       (m_read),
        .c_m_wr_o         (m_wr),
        .c_m_address_o    (m_address),
        .c_m_write_data_o (m_write_data),
        .c_m_read_data_i  (m_read_data),
        .m_read_done      (m_read_done),
        .m_write_done     (m_write_done)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;
    int mem_lat    = 2;

    logic [31:0] main_mem [MEM_WORDS];
    logic [31:0] ref_mem  [MEM_WORDS];

    // Reference cache: per set a recency list of tags, index 0 most recent.
    int m_tag   [8][4];
    bit m_dirty [8][4];
    int m_cnt   [8];

    typedef struct {
        logic [31:0]  addr;
        logic         rd;
        logic         wr;
        logic [3:0]   be;
        logic [31:0]  wdata;
        bit           exp_miss;
        bit           exp_wb;
        logic [29:0]  exp_wb_addr;
        logic [127:0] exp_wb_data;
        logic [31:0]  exp_rdata;
    } vec_t;

    vec_t vecs [NV];

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        m_read_done  = 1'b0;
        m_write_done = 1'b0;
        @(negedge clock);
    endtask

    task automatic doReset();
        reset  = 1'b1;
        c_read = 1'b0;
        c_wr   = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic modelReset();
        for (int s = 0; s < 8; s++)
            m_cnt[s] = 0;
    endtask

    task automatic modelAccess(input logic [31:0] a, input bit is_wr, output bit miss,
                               output bit wb, output logic [29:0] wb_block);
        int s, t, pos, top;
        bit d;
        s = int'(a[6:4]);
        t = int'(a[31:7]);
        pos = -1;
        wb = 1'b0;
        wb_block = '0;
        for (int i = 0; i < m_cnt[s]; i++)
            if (m_tag[s][i] == t) pos = i;
        miss = (pos < 0);
        if (miss) begin
            d = 1'b0;
            if (m_cnt[s] == 4) begin
                wb = m_dirty[s][3];
                wb_block = 30'(m_tag[s][3] * 8 + s);
                m_cnt[s] = 3;
            end
            top = m_cnt[s];
            m_cnt[s]++;
        end else begin
            d = m_dirty[s][pos];
            top = pos;
        end
        for (int i = top; i > 0; i--) begin
            m_tag[s][i]   = m_tag[s][i-1];
            m_dirty[s][i] = m_dirty[s][i-1];
        end
        m_tag[s][0]   = t;
        m_dirty[s][0] = d | is_wr;
    endtask

    // One CPU access including the memory side; called and returns at a falling edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic rd, input logic wr,
                                 input logic [3:0] be, input logic [31:0] wd,
                                 output logic [31:0] rdata, output int busy_cycles,
                                 output bit wb_seen, output logic [29:0] wb_addr,
                                 output logic [127:0] wb_data);
        int cnt, blk;
        bit rd_seen;
        address = addr;
        c_read  = rd;
        c_wr    = wr;
        byte_en = be;
        wr_data = wd;
        busy_cycles = 0;
        wb_seen = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        cnt = 0;
        rd_seen = 1'b0;
        #1;
        while (busywait === 1'b1 && busy_cycles < BUDGET) begin
            checkOutput("no_overlap", 128'(m_read & m_wr), 128'd0);
            blk = int'(m_address);
            if (m_wr) begin
                checkOutput("wb_before_refill", 128'(rd_seen), 128'd0);
                if (cnt == 0) begin
                    wb_addr = m_address;
                    wb_data = m_write_data;
                end else begin
                    checkOutput("wb_addr_held", 128'(m_address), 128'(wb_addr));
                    checkOutput("wb_data_held", m_write_data, wb_data);
                end
                cnt++;
                if (cnt >= mem_lat) begin
                    m_write_done = 1'b1;
                    wb_seen = 1'b1;
                    if (blk < MEM_WORDS / 4)
                        for (int k = 0; k < 4; k++)
                            main_mem[blk*4 + k] = m_write_data[k*32 +: 32];
                    cnt = 0;
                end
            end else if (m_read) begin
                rd_seen = 1'b1;
                cnt++;
                if (cnt >= mem_lat) begin
                    m_read_done = 1'b1;
                    m_read_data = '0;
                    if (blk < MEM_WORDS / 4)
                        m_read_data = {main_mem[blk*4+3], main_mem[blk*4+2],
                                       main_mem[blk*4+1], main_mem[blk*4]};
                    cnt = 0;
                end
            end
            step();
            busy_cycles++;
        end
        if (busy_cycles >= BUDGET) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL access_timeout: busywait still %0b after %0d cycles, required 0", busywait, BUDGET);
        end
        rdata = c_data;
        step();
        c_read = 1'b0;
        c_wr   = 1'b0;
    endtask

    logic [31:0]  rdata;
    logic [29:0]  wb_addr, exp_wb_addr;
    logic [127:0] wb_data, exp_block;
    int           busy, exp_busy, wi;
    bit           wb_seen, miss, exp_wb;
    logic [31:0]  exp_word;

    initial begin
        reset = 1'b1; address = '0; c_read = 1'b0; c_wr = 1'b0; byte_en = '0; wr_data = '0;
        m_read_data = '0; m_read_done = 1'b0; m_write_done = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++)
            main_mem[i] = 32'hC0DE0000 | 32'(i);
        @(negedge clock);

        doReset();
        checkOutput("reset_busywait", 128'(busywait), 128'd0);
        checkOutput("reset_m_read", 128'(m_read), 128'd0);
        checkOutput("reset_m_wr", 128'(m_wr), 128'd0);
        checkOutput("reset_m_address", 128'(m_address), 128'd0);
        checkOutput("reset_m_write_data", m_write_data, 128'd0);
        checkOutput("reset_c_data", 128'(c_data), 128'd0);

        // First read after reset, refill supplied by hand.
        address = 32'h0000000A; c_read = 1'b1; #1;
        checkOutput("t1_miss_busywait", 128'(busywait), 128'd1);
        step();
        checkOutput("t1_m_read", 128'(m_read), 128'd1);
        checkOutput("t1_m_wr", 128'(m_wr), 128'd0);
        checkOutput("t1_m_address", 128'(m_address), 128'd0);
        m_read_data = {32'h0, 32'h11223344, 32'h0, 32'h0};
        m_read_done = 1'b1;
        step();
        checkOutput("t1_hit_busywait", 128'(busywait), 128'd0);
        checkOutput("t1_data", 128'(c_data), 128'h11223344);
        step();
        c_read = 1'b0;

        doReset();
        vecs[0]  = '{32'h014, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 30'h0, 128'h0, 32'hC0DE0005};
        vecs[1]  = '{32'h014, 1'b0, 1'b1, 4'hF, 32'hAABBCCDD, 1'b0, 1'b0, 30'h0, 128'h0, 32'h0};
        vecs[2]  = '{32'h014, 1'b0, 1'b1, 4'h3, 32'hDEADBEEF, 1'b0, 1'b0, 30'h0, 128'h0, 32'h0};
        vecs[3]  = '{32'h014, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0, 1'b0, 30'h0, 128'h0, 32'hAABBBEEF};
        vecs[4]  = '{32'h000, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 30'h0, 128'h0, 32'hC0DE0000};
        vecs[5]  = '{32'h080, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 30'h0, 128'h0, 32'hC0DE0020};
        vecs[6]  = '{32'h100, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 30'h0, 128'h0, 32'hC0DE0040};
        vecs[7]  = '{32'h180, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 30'h0, 128'h0, 32'hC0DE0060};
        vecs[8]  = '{32'h000, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0, 1'b0, 30'h0, 128'h0, 32'hC0DE0000};
        vecs[9]  = '{32'h200, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 30'h0, 128'h0, 32'hC0DE0080};
        vecs[10] = '{32'h000, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0, 1'b0, 30'h0, 128'h0, 32'hC0DE0000};
        vecs[11] = '{32'h080, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 30'h0, 128'h0, 32'hC0DE0020};
        vecs[12] = '{32'h004, 1'b1, 1'b1, 4'hC, 32'h12345678, 1'b0, 1'b0, 30'h0, 128'h0, 32'h0};
        vecs[13] = '{32'h004, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0, 1'b0, 30'h0, 128'h0, 32'h12340001};
        vecs[14] = '{32'h094, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 30'h0, 128'h0, 32'hC0DE0025};
        vecs[15] = '{32'h114, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 30'h0, 128'h0, 32'hC0DE0045};
        vecs[16] = '{32'h194, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 30'h0, 128'h0, 32'hC0DE0065};
        vecs[17] = '{32'h214, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 30'h1,
                     128'hC0DE0007_C0DE0006_AABBBEEF_C0DE0004, 32'hC0DE0085};
        vecs[18] = '{32'h014, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 30'h0, 128'h0, 32'hAABBBEEF};
        vecs[19] = '{32'h018, 1'b0, 1'b1, 4'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 30'h0, 128'h0, 32'h0};
        vecs[20] = '{32'h018, 1'b1, 1'b0, 4'h0, 32'h0,        1'b0, 1'b0, 30'h0, 128'h0, 32'hC0DE0006};

        mem_lat = 2;
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].be, vecs[i].wdata,
                          rdata, busy, wb_seen, wb_addr, wb_data);
            exp_busy = vecs[i].exp_miss ? (1 + mem_lat + (vecs[i].exp_wb ? mem_lat : 0)) : 0;
            checkOutput($sformatf("vec%0d_busy_cycles", i), 128'(busy), 128'(exp_busy));
            checkOutput($sformatf("vec%0d_writeback", i), 128'(wb_seen), 128'(vecs[i].exp_wb));
            if (vecs[i].exp_wb) begin
                checkOutput($sformatf("vec%0d_wb_addr", i), 128'(wb_addr), 128'(vecs[i].exp_wb_addr));
                checkOutput($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].exp_wb_data);
            end
            if (vecs[i].rd && !vecs[i].wr)
                checkOutput($sformatf("vec%0d_rdata", i), 128'(rdata), 128'(vecs[i].exp_rdata));
        end

        // Reset in the middle of a refill; the late done pulse must be ignored.
        doReset();
        address = 32'h300; c_read = 1'b1;
        step();
        checkOutput("t5_m_read", 128'(m_read), 128'd1);
        step();
        reset = 1'b1; c_read = 1'b0;
        step();
        reset = 1'b0; #1;
        checkOutput("t5_busywait", 128'(busywait), 128'd0);
        checkOutput("t5_m_read_off", 128'(m_read), 128'd0);
        m_read_data = '1;
        m_read_done = 1'b1;
        step();
        checkOutput("t5_late_done_busywait", 128'(busywait), 128'd0);
        checkOutput("t5_late_done_m_read", 128'(m_read), 128'd0);
        applyStimulus(32'h300, 1'b1, 1'b0, 4'h0, 32'h0, rdata, busy, wb_seen, wb_addr, wb_data);
        checkOutput("t5_reread_busy_cycles", 128'(busy), 128'(1 + mem_lat));
        checkOutput("t5_reread_data", 128'(rdata), 128'hC0DE00C0);

        // Random traffic against the reference cache and a flat memory image.
        for (int i = 0; i < MEM_WORDS; i++) begin
            main_mem[i] = $urandom;
            ref_mem[i]  = main_mem[i];
        end
        doReset();
        modelReset();
        for (int n = 0; n < 300; n++) begin
            logic rd, wr;
            logic [3:0] be;
            logic [31:0] wd, a;
            int op;
            wi = int'($urandom_range(0, MEM_WORDS - 1));
            a  = 32'(wi * 4) | 32'($urandom_range(0, 3));
            op = int'($urandom_range(0, 3));
            rd = (op != 2);
            wr = (op >= 2);
            be = 4'($urandom);
            wd = $urandom;
            mem_lat = int'($urandom_range(1, 3));
            exp_word = ref_mem[wi];
            modelAccess(a, wr, miss, exp_wb, exp_wb_addr);
            exp_block = {ref_mem[int'(exp_wb_addr)*4+3], ref_mem[int'(exp_wb_addr)*4+2],
                         ref_mem[int'(exp_wb_addr)*4+1], ref_mem[int'(exp_wb_addr)*4]};
            applyStimulus(a, rd, wr, be, wd, rdata, busy, wb_seen, wb_addr, wb_data);
            exp_busy = miss ? (1 + mem_lat + (exp_wb ? mem_lat : 0)) : 0;
            checkOutput("rnd_busy_cycles", 128'(busy), 128'(exp_busy));
            checkOutput("rnd_writeback", 128'(wb_seen), 128'(exp_wb));
            if (exp_wb) begin
                checkOutput("rnd_wb_addr", 128'(wb_addr), 128'(exp_wb_addr));
                checkOutput("rnd_wb_data", wb_data, exp_block);
            end
            if (rd && !wr)
                checkOutput("rnd_rdata", 128'(rdata), 128'(exp_word));
            if (wr)
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[wi][b*8 +: 8] = wd[b*8 +: 8];
            if ($urandom_range(0, 7) == 0) begin
                step();
                checkOutput("rnd_idle_busywait", 128'(busywait), 128'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
